// File: rtl/seq_sched_pkg.sv
// Shared types and helpers for the lane pattern scheduler.
package seq_sched_pkg;

   localparam int NUM_LANES = 6;

   typedef logic [2:0] lane_code_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FIRST  = 3'd1,
      WAIT   = 3'd2,
      SECOND = 3'd3,
      DONE   = 3'd4
   } sched_state_e;

   // Lane code to one-hot lane vector; codes 6 and 7 map to no lane.
   function automatic logic [NUM_LANES-1:0] onehot6(input lane_code_t c);
      logic [NUM_LANES-1:0] r;
      case (c)
         3'd0:    r = 6'b000001;
         3'd1:    r = 6'b000010;
         3'd2:    r = 6'b000100;
         3'd3:    r = 6'b001000;
         3'd4:    r = 6'b010000;
         3'd5:    r = 6'b100000;
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic lane_bad(input lane_code_t c);
      return (c > 3'd5);
   endfunction

endpackage

// File: rtl/seq_rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, wrapping. Purely combinational.
module seq_rr_arbiter
   import seq_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   idx
);

   // Scan NREQ positions starting at ptr; the first hit wins.
   always_comb begin
      int  j;
      logic found;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!found && req[j]) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = IW'(j);
         end
      end
   end

endmodule

// File: rtl/seq_pattern_sched.sv
// Shares six stimulus lanes among NREQ requesters; each grant plays one
// "w ##dly y" pattern. All outputs are registered, so every lane/done pulse
// appears one cycle after the state that produces it.
module seq_pattern_sched
   import seq_sched_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int DLY_W = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*3-1:0]      req_w,
   input  logic [NREQ*3-1:0]      req_y,
   input  logic [NREQ*DLY_W-1:0]  req_dly,
   input  logic                   abort,
   output logic [NREQ-1:0]        gnt,
   output logic [NREQ-1:0]        done,
   output logic [NUM_LANES-1:0]   lane_o,
   output logic                   busy,
   output logic                   code_err
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   sched_state_e         state_q, state_d;
   logic [IW-1:0]        ptr_q, ptr_d, gidx_q, gidx_d, arb_idx, ptr_inc;
   logic [NREQ-1:0]      arb_gnt, gnt_d, done_d;
   lane_code_t           w_q, w_d, y_q, y_d;
   logic [DLY_W-1:0]     dly_q, dly_d, cnt_q, cnt_d;
   logic [NUM_LANES-1:0] lane_d;
   logic                 err_d;

   seq_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
      .req (req),
      .ptr (ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   // Pointer moves to the requester after the current grantee.
   assign ptr_inc = (int'(gidx_q) == NREQ-1) ? '0 : gidx_q + IW'(1);

   // Next state, latched fields and next output values; abort overrides all.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gidx_d  = gidx_q;
      w_d     = w_q;
      y_d     = y_q;
      dly_d   = dly_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt;
      done_d  = '0;
      lane_d  = '0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (!abort && (|req)) begin
               gidx_d  = arb_idx;
               gnt_d   = arb_gnt;
               w_d     = req_w[3*int'(arb_idx) +: 3];
               y_d     = req_y[3*int'(arb_idx) +: 3];
               dly_d   = req_dly[DLY_W*int'(arb_idx) +: DLY_W];
               state_d = FIRST;
            end
         end
         FIRST: begin
            lane_d = onehot6(w_q);
            err_d  = lane_bad(w_q);
            if (dly_q == '0) begin
               lane_d  = lane_d | onehot6(y_q);
               err_d   = err_d | lane_bad(y_q);
               state_d = DONE;
            end else if (dly_q == DLY_W'(1)) begin
               state_d = SECOND;
            end else begin
               cnt_d   = dly_q - DLY_W'(1);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == DLY_W'(1)) state_d = SECOND;
            else                    cnt_d   = cnt_q - DLY_W'(1);
         end
         SECOND: begin
            lane_d  = onehot6(y_q);
            err_d   = lane_bad(y_q);
            state_d = DONE;
         end
         DONE: begin
            done_d  = gnt;
            ptr_d   = ptr_inc;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (abort && (state_q != IDLE)) begin
         state_d = IDLE;
         gnt_d   = '0;
         done_d  = '0;
         lane_d  = '0;
         err_d   = 1'b0;
         ptr_d   = ptr_inc;
      end
   end

   // State, latched request fields and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         gidx_q   <= '0;
         w_q      <= '0;
         y_q      <= '0;
         dly_q    <= '0;
         cnt_q    <= '0;
         gnt      <= '0;
         done     <= '0;
         lane_o   <= '0;
         busy     <= 1'b0;
         code_err <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         gidx_q   <= gidx_d;
         w_q      <= w_d;
         y_q      <= y_d;
         dly_q    <= dly_d;
         cnt_q    <= cnt_d;
         gnt      <= gnt_d;
         done     <= done_d;
         lane_o   <= lane_d;
         busy     <= (state_d != IDLE);
         code_err <= err_d;
      end
   end

endmodule

// File: tb/tb_seq_pattern_sched.sv
// Directed bench for seq_pattern_sched: table of single-requester patterns
// plus hand-written round-robin, abort and reset sequences.
module tb_seq_pattern_sched;

   localparam int NREQ  = 4;
   localparam int DLY_W = 4;

   logic                  clk = 1'b0;
   logic                  reset_n;
   logic [NREQ-1:0]       req;
   logic [NREQ*3-1:0]     req_w, req_y;
   logic [NREQ*DLY_W-1:0] req_dly;
   logic                  abort;
   logic [NREQ-1:0]       gnt, done;
   logic [5:0]            lane_o;
   logic                  busy, code_err;

   int nchk = 0;
   int nerr = 0;

   typedef struct {
      int         idx;
      logic [2:0] w;
      logic [2:0] y;
      logic [3:0] dly;
      logic [5:0] e_first;
      logic [5:0] e_second;
      logic       e_err1;
      logic       e_err2;
   } vec_t;

   vec_t vecs[7];

   seq_pattern_sched #(.NREQ(NREQ), .DLY_W(DLY_W)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (req),
      .req_w    (req_w),
      .req_y    (req_y),
      .req_dly  (req_dly),
      .abort    (abort),
      .gnt      (gnt),
      .done     (done),
      .lane_o   (lane_o),
      .busy     (busy),
      .code_err (code_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_fields(input int idx, input logic [2:0] w, input logic [2:0] y,
                             input logic [3:0] dly);
      req_w[3*idx +: 3]         = w;
      req_y[3*idx +: 3]         = y;
      req_dly[DLY_W*idx +: DLY_W] = dly;
   endtask

   // Bounded wait for a nonzero gnt (sel=0) or done (sel=1).
   task automatic wait_nz(input bit sel, output logic [NREQ-1:0] val);
      bit hit;
      hit = 1'b0;
      val = '0;
      for (int k = 0; k < 40 && !hit; k++) begin
         @(negedge clk);
         if (sel ? (done != '0) : (gnt != '0)) begin
            hit = 1'b1;
            val = sel ? done : gnt;
         end
      end
      if (!hit) begin
         nchk++;
         nerr++;
         $display("FAIL wait_timeout sel=%0d: got no pulse, required one within 40 cycles", sel);
      end
   endtask

   task automatic run_vec(input vec_t v);
      @(negedge clk);
      set_fields(v.idx, v.w, v.y, v.dly);
      req = '0;
      req[v.idx] = 1'b1;
      @(negedge clk);
      chk("gnt", gnt, 32'(1) << v.idx);
      chk("busy", busy, 1);
      // Fields and req change after grant; the latched pattern must play on.
      req = '0;
      req_w = '1;
      req_y = '1;
      req_dly = '1;
      @(negedge clk);
      chk("lane_first", lane_o, v.e_first);
      chk("err_first", code_err, v.e_err1);
      if (v.dly != 0) begin
         for (int k = 1; k < int'(v.dly); k++) begin
            @(negedge clk);
            chk("lane_gap", lane_o, 0);
            chk("done_gap", done, 0);
         end
         @(negedge clk);
         chk("lane_second", lane_o, v.e_second);
         chk("err_second", code_err, v.e_err2);
      end
      @(negedge clk);
      chk("done", done, 32'(1) << v.idx);
      chk("lane_after", lane_o, 0);
      chk("gnt_held", gnt, 32'(1) << v.idx);
      @(negedge clk);
      chk("done_1cyc", done, 0);
      chk("gnt_clr", gnt, 0);
      chk("busy_idle", busy, 0);
   endtask

   initial begin
      logic [NREQ-1:0] g;
      vecs[0] = '{0, 3'd0, 3'd1, 4'd2,  6'b000001, 6'b000010, 1'b0, 1'b0};
      vecs[1] = '{1, 3'd2, 3'd4, 4'd0,  6'b010100, 6'b000000, 1'b0, 1'b0};
      vecs[2] = '{2, 3'd5, 3'd3, 4'd1,  6'b100000, 6'b001000, 1'b0, 1'b0};
      vecs[3] = '{3, 3'd7, 3'd0, 4'd3,  6'b000000, 6'b000001, 1'b1, 1'b0};
      vecs[4] = '{0, 3'd1, 3'd6, 4'd15, 6'b000010, 6'b000000, 1'b0, 1'b1};
      vecs[5] = '{2, 3'd4, 3'd4, 4'd0,  6'b010000, 6'b000000, 1'b0, 1'b0};
      vecs[6] = '{1, 3'd6, 3'd7, 4'd0,  6'b000000, 6'b000000, 1'b1, 1'b0};

      reset_n = 1'b0;
      req = '0; req_w = '0; req_y = '0; req_dly = '0; abort = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_gnt", gnt, 0);
      chk("rst_done", done, 0);
      chk("rst_lane", lane_o, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", code_err, 0);
      reset_n = 1'b1;

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Round robin from a fresh pointer: 0,1,2,3,0 with done before each new grant.
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < NREQ; i++) set_fields(i, 3'd0, 3'd1, 4'd1);
      req = '1;
      for (int i = 0; i < 5; i++) begin
         wait_nz(1'b0, g);
         chk("rr_gnt", g, 32'(1) << (i % NREQ));
         wait_nz(1'b1, g);
         chk("rr_done", g, 32'(1) << (i % NREQ));
         if (i == 4) req = '0;
      end

      // Abort in WAIT: no Y, no done, idle next cycle; pointer moves past grantee.
      @(negedge clk);
      set_fields(1, 3'd0, 3'd1, 4'd8);
      req = 4'b0010;
      @(negedge clk);
      chk("ab_gnt", gnt, 4'b0010);
      @(negedge clk);
      chk("ab_w", lane_o, 6'b000001);
      req = '0;
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("ab_busy", busy, 0);
      chk("ab_gnt_clr", gnt, 0);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("ab_no_lane", lane_o, 0);
         chk("ab_no_done", done, 0);
      end
      // Pointer now 2: requesters 0,1,3 pending -> 3 wins. Abort it in FIRST.
      set_fields(3, 3'd2, 3'd3, 4'd2);
      req = 4'b1011;
      @(negedge clk);
      chk("ab_next_gnt", gnt, 4'b1000);
      abort = 1'b1;
      req = '0;
      @(negedge clk);
      abort = 1'b0;
      chk("ab_first_lane", lane_o, 0);
      chk("ab_first_gnt", gnt, 0);

      // Abort in IDLE blocks a grant that cycle only.
      set_fields(0, 3'd3, 3'd3, 4'd0);
      req = 4'b0001;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("idle_ab_gnt", gnt, 0);
      @(negedge clk);
      chk("idle_ab_gnt2", gnt, 4'b0001);
      req = '0;
      wait_nz(1'b1, g);
      chk("idle_ab_done", g, 4'b0001);

      // Reset while in SECOND: outputs clear at once, pointer back to 0.
      @(negedge clk);
      set_fields(2, 3'd0, 3'd1, 4'd2);
      req = 4'b0100;
      @(negedge clk);
      chk("rs_gnt", gnt, 4'b0100);
      @(negedge clk);
      chk("rs_w", lane_o, 6'b000001);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("rs_gnt0", gnt, 0);
      chk("rs_busy0", busy, 0);
      chk("rs_lane0", lane_o, 0);
      chk("rs_done0", done, 0);
      req = '0;
      repeat (2) begin
         @(negedge clk);
         chk("rs_hold_done", done, 0);
         chk("rs_hold_lane", lane_o, 0);
      end
      reset_n = 1'b1;
      req = '1;
      @(negedge clk);
      chk("rs_ptr0_gnt", gnt, 4'b0001);
      abort = 1'b1;
      req = '0;
      @(negedge clk);
      abort = 1'b0;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
